ctrl_cfg_scheduler: RTL and testbench
=====================================

// Module: ctrl_cfg_scheduler
// PURPOSE
// Sits ahead of the chain of RMT stages on the control path. Merges two AXIS control-packet sources (s0 = host config, s1 = local table-update engine) onto the single push-only c_m_axis control bus, with packet-granular round-robin arbitration.
// Before each packet it holds PHV ingress (pipe_hold) and waits for the in-flight PHV count to reach zero, so table/key/action writes never race live packets.
// PARAMETERS
// C_S_AXIS_DATA_WIDTH   512   control tdata width; tkeep = /8
// C_S_AXIS_TUSER_WIDTH  128   control tuser width
// INFL_W                8     width of in-flight PHV counter
// DRAIN_TIMEOUT         1024  max cycles in HOLD before forcing SEND
// PORTS
// axis_clk            in   1        clock
// aresetn             in   1        synchronous active-low reset
// s{0,1}_axis_tdata   in   DATA     source n data
// s{0,1}_axis_tuser   in   TUSER    source n user
// s{0,1}_axis_tkeep   in   DATA/8   source n keep
// s{0,1}_axis_tvalid  in   1        source n valid
// s{0,1}_axis_tlast   in   1        source n last beat
// s{0,1}_axis_tready  out  1        source n ready
// c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  as above  to first stage (no tready)
// phv_in_valid_mon    in   1        PHV accepted into first stage
// phv_out_valid_mon   in   1        PHV leaving last stage
// pipe_hold           out  1        1 = parser must not issue PHVs
// cfg_busy            out  1        1 when state != IDLE
// drain_timeout_err   out  1        sticky: HOLD exited via timeout
// infl_err            out  1        sticky: counter underflow/overflow attempt
// BEHAVIOUR
// Reset (aresetn=0 at posedge): state=IDLE, all outputs 0, infl_cnt=0, last_grant=1 (s0 wins first tie), timeout cnt=0, sticky flags cleared. Mid-packet reset truncates output; no completion beat is emitted.
// In-flight counter (always active, every state):
// - +1 on phv_in_valid_mon only, -1 on phv_out_valid_mon only, unchanged on both/neither.
// - Decrement at 0 holds 0 and sets infl_err; increment at all-ones holds max and sets infl_err.
// FSM:
// - IDLE: if any sN_axis_tvalid -> latch grant: sole requester, or if both, the one != last_grant; go HOLD. last_grant <= grant.
// - HOLD: pipe_hold=1 (registered; first asserted cycle after leaving IDLE). Timer counts up from 0.
//   - Exit to SEND when infl_cnt==0 and phv_in_valid_mon==0 that cycle.
//   - Else exit to SEND when timer==DRAIN_TIMEOUT-1; set drain_timeout_err.
// - SEND: pipe_hold=1; sN_axis_tready=1 for granted source only; other tready=0.
//   - Each accepted beat is registered to c_m_axis_* one cycle later (latency 1), tvalid=1 that cycle.
//   - Source tvalid=0 mid-packet: output tvalid=0 next cycle; stay SEND.
//   - Accepted beat with tlast=1 -> GAP.
// - GAP: one cycle; tready=0; pipe_hold deasserts the next cycle; -> IDLE.
// - Min back-to-back spacing: 2 idle cycles between packets on c_m_axis (GAP + IDLE), plus HOLD time.
// tready is 0 in IDLE/HOLD/GAP; a requester arriving during another's packet waits. No packet switch mid-packet.
// c_m_axis_tdata/tuser/tkeep/tlast are 0 whenever c_m_axis_tvalid=0.
// TESTING
// 1) Reset, s0 sends 3-beat pkt, infl_cnt=0 -> HOLD 1 cycle, beats on c_m_axis 1 cycle after each accept, tlast on beat 3, pipe_hold drops 2 cycles later.
// 2) s0 and s1 both valid from reset -> s0 packet first, then s1; second tie -> s1 first (alternates).
// 3) Preload 5 PHVs (5 in, 0 out), then s1 request -> stays HOLD until 5 outs; simultaneous in+out leaves count unchanged; SEND starts the cycle after count reaches 0.
// 4) DRAIN_TIMEOUT=16, infl_cnt stuck at 2 -> SEND after exactly 16 HOLD cycles, drain_timeout_err=1 and stays 1.
// 5) s0 deasserts tvalid for 3 cycles mid-packet -> c_m_axis_tvalid gaps 3 cycles, s1_axis_tready stays 0, packet completes intact.
// 6) Assert aresetn=0 during beat 2 of 4 -> next cycle all outputs 0, state IDLE, infl_cnt=0; phv_out with count 0 -> infl_err=1.

Source files
------------

// File: rtl/ctrl_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// ctrl_cfg_scheduler
//
// Merges two AXIS control-packet sources onto the push-only control bus that
// feeds the first RMT stage. Packets are granted one at a time in round-robin
// order. Before a packet is forwarded, PHV ingress is held and the number of
// PHVs still in the pipeline is allowed to drain to zero, so table/key/action
// writes never overlap live packets. A bounded drain timer prevents a stuck
// counter from blocking configuration forever.
//
// Ports
//   axis_clk, aresetn          clock, synchronous active-low reset
//   s0_axis_*                  host configuration source (tdata/tuser/tkeep/
//                              tvalid/tlast in, tready out)
//   s1_axis_*                  local table-update source (same set)
//   c_m_axis_*                 control output to first stage, no back-pressure
//   phv_in_valid_mon           PHV accepted into first stage
//   phv_out_valid_mon          PHV leaving last stage
//   pipe_hold                  1 = parser must not issue PHVs
//   cfg_busy                   1 while a packet is being scheduled/sent
//   drain_timeout_err          sticky: a drain wait ended on timeout
//   infl_err                   sticky: in-flight counter under/overflow attempt
// ---------------------------------------------------------------------------
module ctrl_cfg_scheduler #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int INFL_W               = 8,
    parameter int DRAIN_TIMEOUT        = 1024
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s0_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s0_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s0_axis_tkeep,
    input  logic                              s0_axis_tvalid,
    input  logic                              s0_axis_tlast,
    output logic                              s0_axis_tready,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s1_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s1_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s1_axis_tkeep,
    input  logic                              s1_axis_tvalid,
    input  logic                              s1_axis_tlast,
    output logic                              s1_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,

    input  logic                              phv_in_valid_mon,
    input  logic                              phv_out_valid_mon,
    output logic                              pipe_hold,
    output logic                              cfg_busy,
    output logic                              drain_timeout_err,
    output logic                              infl_err
);

    localparam int TMR_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] SEND = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    logic [1:0]        state;
    logic              grant;       // 0 = s0, 1 = s1
    logic              last_grant;
    logic              next_grant;
    logic [TMR_W-1:0]  timer;
    logic [INFL_W-1:0] infl_cnt;

    logic                             sel_valid;
    logic                             sel_last;
    logic [C_S_AXIS_DATA_WIDTH-1:0]   sel_data;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]  sel_user;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0] sel_keep;
    logic                             accept;

    assign s0_axis_tready = (state == SEND) && !grant;
    assign s1_axis_tready = (state == SEND) &&  grant;
    assign cfg_busy       = (state != IDLE);

    always_comb begin
        sel_valid = s0_axis_tvalid;
        sel_last  = s0_axis_tlast;
        sel_data  = s0_axis_tdata;
        sel_user  = s0_axis_tuser;
        sel_keep  = s0_axis_tkeep;
        if (grant) begin
            sel_valid = s1_axis_tvalid;
            sel_last  = s1_axis_tlast;
            sel_data  = s1_axis_tdata;
            sel_user  = s1_axis_tuser;
            sel_keep  = s1_axis_tkeep;
        end
        accept = (state == SEND) && sel_valid;
    end

    // On a tie the source that did not win last time is granted.
    always_comb begin
        next_grant = s1_axis_tvalid;
        if (s0_axis_tvalid && s1_axis_tvalid) begin
            next_grant = !last_grant;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            state             <= IDLE;
            grant             <= 1'b0;
            last_grant        <= 1'b1;
            timer             <= '0;
            infl_cnt          <= '0;
            pipe_hold         <= 1'b0;
            drain_timeout_err <= 1'b0;
            infl_err          <= 1'b0;
            c_m_axis_tvalid   <= 1'b0;
            c_m_axis_tlast    <= 1'b0;
            c_m_axis_tdata    <= '0;
            c_m_axis_tuser    <= '0;
            c_m_axis_tkeep    <= '0;
        end else begin
            // In-flight PHV counter: saturates at both ends and flags the attempt.
            if (phv_in_valid_mon && !phv_out_valid_mon) begin
                if (infl_cnt == '1) begin
                    infl_err <= 1'b1;
                end else begin
                    infl_cnt <= infl_cnt + 1'b1;
                end
            end else if (phv_out_valid_mon && !phv_in_valid_mon) begin
                if (infl_cnt == '0) begin
                    infl_err <= 1'b1;
                end else begin
                    infl_cnt <= infl_cnt - 1'b1;
                end
            end

            // Output register: payload is forced to zero on idle cycles.
            c_m_axis_tvalid <= accept;
            c_m_axis_tlast  <= accept && sel_last;
            c_m_axis_tdata  <= accept ? sel_data : '0;
            c_m_axis_tuser  <= accept ? sel_user : '0;
            c_m_axis_tkeep  <= accept ? sel_keep : '0;

            case (state)
                IDLE: begin
                    if (s0_axis_tvalid || s1_axis_tvalid) begin
                        grant      <= next_grant;
                        last_grant <= next_grant;
                        timer      <= '0;
                        pipe_hold  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    // A PHV entering this very cycle is not yet counted, so it
                    // also blocks the drain exit.
                    if ((infl_cnt == '0) && !phv_in_valid_mon) begin
                        state <= SEND;
                    end else if (timer == TMR_LAST) begin
                        drain_timeout_err <= 1'b1;
                        state             <= SEND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SEND: begin
                    if (accept && sel_last) begin
                        state <= GAP;
                    end
                end
                default: begin
                    pipe_hold <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ctrl_cfg_scheduler
//
// Self-checking bench for ctrl_cfg_scheduler. A reference table covers the
// basic single-packet timing; directed sequences cover arbitration, drain,
// timeout, mid-packet stalls and reset; a randomized run is checked against a
// transaction-level model (beat queues per source, saturating PHV count).
// ---------------------------------------------------------------------------
module tb_ctrl_cfg_scheduler;

    localparam int DW     = 64;
    localparam int UW     = 16;
    localparam int KW     = DW / 8;
    localparam int IW     = 4;
    localparam int DTO    = 16;
    localparam int MAXCNT = (1 << IW) - 1;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s0_tdata, s1_tdata, c_tdata;
    logic [UW-1:0] s0_tuser, s1_tuser, c_tuser;
    logic [KW-1:0] s0_tkeep, s1_tkeep, c_tkeep;
    logic          s0_tvalid, s1_tvalid, s0_tlast, s1_tlast, s0_tready, s1_tready;
    logic          c_tvalid, c_tlast;
    logic          phv_in, phv_out, pipe_hold, cfg_busy, dto_err, infl_err;

    ctrl_cfg_scheduler #(
        .C_S_AXIS_DATA_WIDTH  (DW),
        .C_S_AXIS_TUSER_WIDTH (UW),
        .INFL_W               (IW),
        .DRAIN_TIMEOUT        (DTO)
    ) dut (
        .axis_clk          (clk),
        .aresetn           (aresetn),
        .s0_axis_tdata     (s0_tdata),
        .s0_axis_tuser     (s0_tuser),
        .s0_axis_tkeep     (s0_tkeep),
        .s0_axis_tvalid    (s0_tvalid),
        .s0_axis_tlast     (s0_tlast),
        .s0_axis_tready    (s0_tready),
        .s1_axis_tdata     (s1_tdata),
        .s1_axis_tuser     (s1_tuser),
        .s1_axis_tkeep     (s1_tkeep),
        .s1_axis_tvalid    (s1_tvalid),
        .s1_axis_tlast     (s1_tlast),
        .s1_axis_tready    (s1_tready),
        .c_m_axis_tdata    (c_tdata),
        .c_m_axis_tuser    (c_tuser),
        .c_m_axis_tkeep    (c_tkeep),
        .c_m_axis_tvalid   (c_tvalid),
        .c_m_axis_tlast    (c_tlast),
        .phv_in_valid_mon  (phv_in),
        .phv_out_valid_mon (phv_out),
        .pipe_hold         (pipe_hold),
        .cfg_busy          (cfg_busy),
        .drain_timeout_err (dto_err),
        .infl_err          (infl_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        bit            last;
        int unsigned   pre_idle;
    } beat_t;

    typedef struct {
        bit            s0v;
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        bit            last;
        bit            e_rdy0, e_rdy1, e_cv;
        logic [DW-1:0] e_d;
        logic [UW-1:0] e_u;
        logic [KW-1:0] e_k;
        bit            e_cl, e_hold, e_busy;
    } vec_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          rstn = 1'b0;
    beat_t       q0[$], q1[$];
    int unsigned wait0 = 0, wait1 = 0;
    beat_t       zb, exp_b;
    bit          exp_v = 1'b0;
    int          model_cnt = 0;
    bit          model_err = 1'b0;
    bit          in_pkt0 = 1'b0, in_pkt1 = 1'b0, out_in_pkt = 1'b0, dto_seen = 1'b0;
    bit          rdy0, rdy1;
    int          start_src[$];
    int          gap_log[$];
    int          last_tlast_cyc = 0;
    int          out_idle_in_pkt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_pkt(input int src, input int n, input int gap_idx, input int unsigned gap_len);
        beat_t b;
        bit was_empty;
        was_empty = (src == 0) ? (q0.size() == 0) : (q1.size() == 0);
        for (int i = 0; i < n; i++) begin
            b.data     = {$urandom, $urandom};
            b.user     = 16'($urandom);
            b.keep     = 8'($urandom);
            b.last     = (i == n - 1);
            b.pre_idle = (i == gap_idx) ? gap_len : 0;
            if (src == 0) q0.push_back(b); else q1.push_back(b);
        end
        if (was_empty) begin
            if (src == 0) wait0 = q0[0].pre_idle; else wait1 = q1[0].pre_idle;
        end
    endtask

    // One clock cycle: drive, check registered outputs at negedge, advance the model.
    task automatic step(input bit pin, input bit pout);
        bit v0, v1, a0, a1;
        aresetn = rstn;
        v0 = (q0.size() > 0) && (wait0 == 0);
        v1 = (q1.size() > 0) && (wait1 == 0);
        s0_tvalid = v0; s0_tdata = v0 ? q0[0].data : '0; s0_tuser = v0 ? q0[0].user : '0;
        s0_tkeep = v0 ? q0[0].keep : '0; s0_tlast = v0 ? q0[0].last : 1'b0;
        s1_tvalid = v1; s1_tdata = v1 ? q1[0].data : '0; s1_tuser = v1 ? q1[0].user : '0;
        s1_tkeep = v1 ? q1[0].keep : '0; s1_tlast = v1 ? q1[0].last : 1'b0;
        phv_in = pin; phv_out = pout;
        @(negedge clk);
        chk("c_tvalid", c_tvalid, exp_v);
        chk("c_tdata",  c_tdata,  exp_b.data);
        chk("c_tuser",  c_tuser,  exp_b.user);
        chk("c_tkeep",  c_tkeep,  exp_b.keep);
        chk("c_tlast",  c_tlast,  exp_b.last);
        chk("infl_err", infl_err, model_err);
        chk("tready_excl", s0_tready & s1_tready, 0);
        if (s0_tready || s1_tready) chk("hold_in_send", pipe_hold, 1);
        if (dto_seen) chk("dto_sticky", dto_err, 1);
        dto_seen = dto_seen | dto_err;
        rdy0 = s0_tready;
        rdy1 = s1_tready;
        if (c_tvalid) begin
            if (!out_in_pkt) gap_log.push_back(cyc - last_tlast_cyc);
            out_in_pkt = !c_tlast;
            if (c_tlast) last_tlast_cyc = cyc;
        end else if (out_in_pkt) begin
            out_idle_in_pkt++;
        end
        a0 = v0 && s0_tready;
        a1 = v1 && s1_tready;
        if (!rstn) begin
            exp_v = 1'b0; exp_b = zb; model_cnt = 0; model_err = 1'b0;
            q0.delete(); q1.delete(); wait0 = 0; wait1 = 0;
            in_pkt0 = 1'b0; in_pkt1 = 1'b0; out_in_pkt = 1'b0; dto_seen = 1'b0;
        end else begin
            exp_v = a0 || a1;
            exp_b = a0 ? q0[0] : (a1 ? q1[0] : zb);
            exp_b.pre_idle = 0;
            if (a0) begin
                if (!in_pkt0) start_src.push_back(0);
                in_pkt0 = !q0[0].last;
                void'(q0.pop_front());
                if (q0.size() > 0) wait0 = q0[0].pre_idle;
            end else if (!v0 && wait0 > 0) begin
                wait0--;
            end
            if (a1) begin
                if (!in_pkt1) start_src.push_back(1);
                in_pkt1 = !q1[0].last;
                void'(q1.pop_front());
                if (q1.size() > 0) wait1 = q1[0].pre_idle;
            end else if (!v1 && wait1 > 0) begin
                wait1--;
            end
            if (pin && !pout) begin
                if (model_cnt == MAXCNT) model_err = 1'b1; else model_cnt++;
            end else if (pout && !pin) begin
                if (model_cnt == 0) model_err = 1'b1; else model_cnt--;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(0, 0);
        step(0, 0);
        rstn = 1'b1;
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        while ((q0.size() + q1.size() > 0) && n < budget) begin
            step(0, 0);
            n++;
        end
        chk("queues_drained", q0.size() + q1.size(), 0);
        for (int i = 0; i < 4; i++) step(0, 0);
    endtask

    vec_t vec[8];

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] da, db, dc;
        int n;
        zb = '{data: '0, user: '0, keep: '0, last: 1'b0, pre_idle: 0};
        exp_b = zb;
        da = 64'h1111_2222_3333_4444;
        db = 64'hA5A5_5A5A_0F0F_F0F0;
        dc = 64'hDEAD_BEEF_CAFE_F00D;
        //          s0v d   u        k      last rdy0 rdy1 cv e_d e_u      e_k    cl hold busy
        vec[0] = '{1, da, 16'h0A01, 8'hFF, 0,  0, 0, 0, '0, '0,      '0,    0, 0, 0};
        vec[1] = '{1, da, 16'h0A01, 8'hFF, 0,  0, 0, 0, '0, '0,      '0,    0, 1, 1};
        vec[2] = '{1, da, 16'h0A01, 8'hFF, 0,  1, 0, 0, '0, '0,      '0,    0, 1, 1};
        vec[3] = '{1, db, 16'h0B02, 8'h0F, 0,  1, 0, 1, da, 16'h0A01, 8'hFF, 0, 1, 1};
        vec[4] = '{1, dc, 16'h0C03, 8'h3C, 1,  1, 0, 1, db, 16'h0B02, 8'h0F, 0, 1, 1};
        vec[5] = '{0, '0, '0,       '0,    0,  0, 0, 1, dc, 16'h0C03, 8'h3C, 1, 1, 1};
        vec[6] = '{0, '0, '0,       '0,    0,  0, 0, 0, '0, '0,      '0,    0, 0, 0};
        vec[7] = '{0, '0, '0,       '0,    0,  0, 0, 0, '0, '0,      '0,    0, 0, 0};

        aresetn = 1'b0;
        s0_tvalid = 0; s1_tvalid = 0; s0_tlast = 0; s1_tlast = 0;
        s0_tdata = '0; s1_tdata = '0; s0_tuser = '0; s1_tuser = '0; s0_tkeep = '0; s1_tkeep = '0;
        phv_in = 0; phv_out = 0;
        @(posedge clk); #1;
        do_reset();

        // Single 3-beat packet, cycle by cycle.
        for (int i = 0; i < 8; i++) begin
            aresetn = 1'b1;
            s0_tvalid = vec[i].s0v; s0_tdata = vec[i].d; s0_tuser = vec[i].u;
            s0_tkeep = vec[i].k; s0_tlast = vec[i].last;
            s1_tvalid = 0; s1_tdata = '0; s1_tuser = '0; s1_tkeep = '0; s1_tlast = 0;
            phv_in = 0; phv_out = 0;
            @(negedge clk);
            chk($sformatf("tbl%0d_rdy0", i), s0_tready, vec[i].e_rdy0);
            chk($sformatf("tbl%0d_rdy1", i), s1_tready, vec[i].e_rdy1);
            chk($sformatf("tbl%0d_cv", i),   c_tvalid,  vec[i].e_cv);
            chk($sformatf("tbl%0d_cd", i),   c_tdata,   vec[i].e_d);
            chk($sformatf("tbl%0d_cu", i),   c_tuser,   vec[i].e_u);
            chk($sformatf("tbl%0d_ck", i),   c_tkeep,   vec[i].e_k);
            chk($sformatf("tbl%0d_cl", i),   c_tlast,   vec[i].e_cl);
            chk($sformatf("tbl%0d_hold", i), pipe_hold, vec[i].e_hold);
            chk($sformatf("tbl%0d_busy", i), cfg_busy,  vec[i].e_busy);
            @(posedge clk); #1;
            cyc++;
        end

        // Round-robin: tie from reset goes to s0, the pending s1 then beats s0's second packet.
        do_reset();
        start_src.delete(); gap_log.delete();
        push_pkt(0, 2, 0, 0);
        push_pkt(0, 2, 0, 0);
        push_pkt(1, 2, 0, 0);
        run_until_empty(200);
        chk("arb_count", start_src.size(), 3);
        if (start_src.size() == 3) begin
            chk("arb_first",  start_src[0], 0);
            chk("arb_second", start_src[1], 1);
            chk("arb_third",  start_src[2], 0);
        end
        if (gap_log.size() == 3) begin
            chk("b2b_gap1", gap_log[1], 4);
            chk("b2b_gap2", gap_log[2], 4);
        end else begin
            chk("b2b_gap_count", gap_log.size(), 3);
        end

        // Drain wait: 5 PHVs in flight, SEND only after they have all left.
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0);
        push_pkt(1, 1, 0, 0);
        step(0, 0);
        chk("drain_idle_rdy1", rdy1, 0);
        step(0, 1); chk("drain_w0", rdy1, 0);
        step(0, 1); chk("drain_w1", rdy1, 0);
        step(1, 1); chk("drain_w2", rdy1, 0);
        step(0, 0); chk("drain_w3", rdy1, 0);
        step(0, 1); chk("drain_w4", rdy1, 0);
        step(0, 1); chk("drain_w5", rdy1, 0);
        step(0, 1); chk("drain_w6", rdy1, 0);
        step(0, 0); chk("drain_zero_hold", rdy1, 0);
        step(0, 0); chk("drain_send", rdy1, 1);
        run_until_empty(20);
        chk("drain_no_dto", dto_err, 0);

        // Timeout: count stuck at 2.
        do_reset();
        step(1, 0);
        step(1, 0);
        push_pkt(0, 1, 0, 0);
        step(0, 0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 0);
            if (rdy0) break;
            n++;
        end
        chk("timeout_hold_cycles", n, DTO);
        chk("timeout_err", dto_err, 1);
        step(0, 1);
        step(0, 1);
        push_pkt(1, 2, 0, 0);
        run_until_empty(40);
        chk("timeout_err_sticky", dto_err, 1);

        // Mid-packet stall of 3 cycles; s1 waits.
        do_reset();
        start_src.delete();
        push_pkt(0, 4, 1, 3);
        push_pkt(1, 1, 0, 0);
        out_idle_in_pkt = 0;
        n = 0;
        for (int i = 0; i < 60 && q0.size() > 0; i++) begin
            step(0, 0);
            if (rdy1) n++;
        end
        step(0, 0);
        chk("stall_no_switch", n, 0);
        chk("stall_out_gap", out_idle_in_pkt, 3);
        run_until_empty(40);
        chk("stall_order_cnt", start_src.size(), 2);
        if (start_src.size() == 2) chk("stall_order", start_src[1], 1);

        // Reset during beat 2 of 4, then underflow.
        do_reset();
        push_pkt(0, 4, 0, 0);
        for (int i = 0; i < 30 && q0.size() > 3; i++) step(0, 0);
        chk("rst_reached_beat2", q0.size(), 3);
        rstn = 1'b0;
        step(0, 0);
        rstn = 1'b1;
        chk("rst_hold", pipe_hold, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_rdy0", s0_tready, 0);
        step(0, 0);
        step(0, 1);
        step(0, 0);
        chk("underflow_err", infl_err, 1);

        // Overflow at counter max.
        do_reset();
        for (int i = 0; i < MAXCNT; i++) step(1, 0);
        step(0, 0);
        chk("no_overflow_yet", infl_err, 0);
        step(1, 0);
        step(0, 0);
        chk("overflow_err", infl_err, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (q0.size() < 3 && $urandom_range(0, 7) == 0)
                push_pkt(0, $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 2));
            if (q1.size() < 3 && $urandom_range(0, 7) == 0)
                push_pkt(1, $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 2));
            rstn = ($urandom_range(0, 499) != 0);
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
            rstn = 1'b1;
        end
        run_until_empty(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
